// File: rtl/definitions.sv
// Shared controller types: opcodes, register names, the issued instruction
// record and the issue-stage FSM states.
package definitions;

    typedef enum logic [2:0] {
        LD   = 3'd0,
        ST   = 3'd1,
        OUT  = 3'd2,
        SHFL = 3'd3,
        NAND = 3'd4,
        ADD  = 3'd5,
        JMP  = 3'd6,
        HALT = 3'd7
    } t_opcode;

    typedef enum logic [1:0] {
        R0  = 2'd0,
        R1  = 2'd1,
        R2  = 2'd2,
        IMM = 2'd3
    } t_reg_name;

    localparam int IMM_W = 8;

    typedef struct packed {
        t_opcode          opcode;
        t_reg_name        src1;
        t_reg_name        src2;
        logic [IMM_W-1:0] imm;
    } t_inst;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } t_issue_state;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO of t_inst records with flush; head is visible on rdata_o
// whenever empty_o is low.
module inst_fifo
    import definitions::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic                           flush_i,
    input  t_inst                          wdata_i,
    output t_inst                          rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           full_o,
    output logic                           empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    t_inst          mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; entries are only read when
    // count_q says they were written, so resetting them buys nothing.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/inst_issue.sv
// Instruction issue buffer: loader handshake into a FIFO, one presented
// instruction in an output slot honouring controller stall and flush.
module inst_issue
    import definitions::*;
#(
    parameter int DEPTH = 4,
    parameter int DATAW = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  t_opcode                        in_opcode,
    input  t_reg_name                      in_src1,
    input  t_reg_name                      in_src2,
    input  logic [DATAW-1:0]               in_imm,
    input  logic                           stalled,
    input  logic                           internal_reset,
    output logic                           instv,
    output t_opcode                        opcode,
    output t_reg_name                      src1,
    output t_reg_name                      src2,
    output logic [DATAW-1:0]               imm,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [15:0]                    issued_cnt
);

    t_issue_state   state_q, state_d;
    t_inst          slot_q, slot_d;
    logic [15:0]    issued_q, issued_d;
    logic           rdy_en_q;

    t_inst          in_inst, fifo_rdata;
    logic           fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic           handshake, consume, slot_free, bypass;

    assign in_inst = '{opcode: in_opcode, src1: in_src1, src2: in_src2,
                       imm: IMM_W'(in_imm)};

    // rdy_en_q keeps in_ready low while reset is held and for the cycle it releases.
    assign in_ready  = rdy_en_q & ~fifo_full & ~internal_reset;
    assign handshake = in_valid & in_ready;
    assign consume   = instv & ~stalled;
    assign slot_free = ~instv | consume;
    assign bypass    = handshake & fifo_empty & slot_free;
    assign fifo_push = handshake & ~bypass;
    assign fifo_pop  = slot_free & ~fifo_empty & ~internal_reset;

    inst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (internal_reset),
        .wdata_i (in_inst),
        .rdata_o (fifo_rdata),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves one unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        issued_d = issued_q;
        if (internal_reset) begin
            state_d = IDLE;
            slot_d  = '0;
        end else begin
            if (consume) issued_d = issued_q + 16'd1;
            if (instv && stalled) begin
                state_d = HOLD;
            end else if (!fifo_empty) begin
                state_d = ISSUE;
                slot_d  = fifo_rdata;
            end else if (bypass) begin
                state_d = ISSUE;
                slot_d  = in_inst;
            end else begin
                state_d = IDLE;
                slot_d  = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            issued_q <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            issued_q <= issued_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign instv      = (state_q != IDLE);
    assign opcode     = slot_q.opcode;
    assign src1       = slot_q.src1;
    assign src2       = slot_q.src2;
    assign imm        = DATAW'(slot_q.imm);
    assign issued_cnt = issued_q;

endmodule
